// File: rtl/code_lock_fsm.sv
// Code-lock controller: synchronised push-buttons, stored code, counted failures with
// timed lockout, and blink-driven alarm/lockout indication.
module code_lock_fsm #(
    parameter int unsigned       CODE_W         = 7,
    parameter int unsigned       MAX_TRIES      = 3,
    parameter int unsigned       LOCKOUT_CYCLES = 4096,
    parameter int unsigned       BLINK_BIT      = 8,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CODE_W-1:0]              code_in,
    input  logic                           set_btn,
    input  logic                           check_btn,
    output logic                           unlocked,
    output logic                           alarm_led,
    output logic [2:0]                     state,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic                           locked_out
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned BLK_W = BLINK_BIT + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_SET_AWAIT = 3'b001,
        ST_OPENED    = 3'b010,
        ST_ALARM     = 3'b011,
        ST_INPUT     = 3'b100,
        ST_LOCKOUT   = 3'b101
    } state_t;

    state_t             r_state;
    logic [CODE_W-1:0]  r_code;
    logic [TRY_W-1:0]   r_tries;
    logic [TMR_W-1:0]   r_timer;
    logic [BLK_W-1:0]   r_blink;
    logic [1:0]         r_chk_sync;
    logic [1:0]         r_set_sync;
    logic               r_chk_hist;
    logic               r_set_hist;

    logic               w_chk;
    logic               w_set;

    // One-cycle press pulses on the synchronised falling edge.
    assign w_chk = r_chk_hist & ~r_chk_sync[1];
    assign w_set = r_set_hist & ~r_set_sync[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_code     <= DEFAULT_CODE;
            r_tries    <= TRY_W'(MAX_TRIES);
            r_timer    <= '0;
            r_blink    <= '0;
            r_chk_sync <= 2'b11;
            r_set_sync <= 2'b11;
            r_chk_hist <= 1'b1;
            r_set_hist <= 1'b1;
        end else begin
            r_chk_sync <= {r_chk_sync[0], check_btn};
            r_set_sync <= {r_set_sync[0], set_btn};
            r_chk_hist <= r_chk_sync[1];
            r_set_hist <= r_set_sync[1];
            r_blink    <= r_blink + BLK_W'(1);

            // Check presses take priority over set presses in every state.
            case (r_state)
                ST_IDLE: begin
                    if (w_chk) r_state <= ST_INPUT;
                end
                ST_INPUT: begin
                    if (w_chk) begin
                        if (code_in == r_code) begin
                            r_state <= ST_OPENED;
                            r_tries <= TRY_W'(MAX_TRIES);
                        end else if (r_tries <= TRY_W'(1)) begin
                            r_state <= ST_LOCKOUT;
                            r_tries <= '0;
                            r_timer <= TMR_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            r_state <= ST_ALARM;
                            r_tries <= r_tries - TRY_W'(1);
                        end
                    end else if (w_set) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OPENED: begin
                    if (w_chk)      r_state <= ST_IDLE;
                    else if (w_set) r_state <= ST_SET_AWAIT;
                end
                ST_SET_AWAIT: begin
                    if (w_chk) begin
                        r_state <= ST_IDLE;
                    end else if (w_set) begin
                        r_code  <= code_in;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ALARM: begin
                    if (w_chk) r_state <= ST_IDLE;
                end
                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                        r_tries <= TRY_W'(MAX_TRIES);
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state      = r_state;
    assign tries_left = r_tries;
    assign unlocked   = (r_state == ST_OPENED);
    assign locked_out = (r_state == ST_LOCKOUT);
    assign alarm_led  = (r_state == ST_ALARM)   ? r_blink[BLINK_BIT]   :
                        (r_state == ST_LOCKOUT) ? r_blink[BLINK_BIT-1] : 1'b0;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: directed scenarios then random pin activity, every cycle
// compared against a pin-history reference model of the lock.
module tb_code_lock_fsm;

    localparam int CW = 7;
    localparam int MT = 3;
    localparam int LC = 16;
    localparam int BB = 2;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_OPEN  = 2;
    localparam int S_ALARM = 3;
    localparam int S_INPUT = 4;
    localparam int S_LOCK  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] code_in;
    logic          set_btn;
    logic          check_btn;
    logic          unlocked;
    logic          alarm_led;
    logic [2:0]    state;
    logic [1:0]    tries_left;
    logic          locked_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int lo_count = 0;

    // Reference model: pin sample history (index 0 = newest) and lock status.
    bit [2:0] c_h = 3'b111;
    bit [2:0] s_h = 3'b111;
    int m_state = 0;
    int m_code  = 0;
    int m_tries = MT;
    int m_left  = 0;
    int m_blink = 0;

    code_lock_fsm #(
        .CODE_W(CW), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC), .BLINK_BIT(BB), .DEFAULT_CODE(7'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .set_btn(set_btn), .check_btn(check_btn),
        .unlocked(unlocked), .alarm_led(alarm_led), .state(state), .tries_left(tries_left),
        .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // A press registers two edges after the pin is first seen low following a high sample.
    task automatic model_edge();
        bit pc, ps;
        if (!rst_n) begin
            m_state = S_IDLE; m_code = 0; m_tries = MT; m_left = 0; m_blink = 0;
            c_h = 3'b111; s_h = 3'b111;
            return;
        end
        pc = c_h[2] && !c_h[1];
        ps = s_h[2] && !s_h[1];
        c_h = {c_h[1:0], check_btn};
        s_h = {s_h[1:0], set_btn};
        m_blink = (m_blink + 1) % (1 << (BB + 1));
        case (m_state)
            S_IDLE:  if (pc) m_state = S_INPUT;
            S_INPUT: begin
                if (pc) begin
                    if (int'(code_in) == m_code) begin
                        m_state = S_OPEN; m_tries = MT;
                    end else begin
                        m_tries = m_tries - 1;
                        if (m_tries == 0) begin
                            m_state = S_LOCK; m_left = LC;
                        end else begin
                            m_state = S_ALARM;
                        end
                    end
                end else if (ps) m_state = S_IDLE;
            end
            S_OPEN: begin
                if (pc) m_state = S_IDLE;
                else if (ps) m_state = S_SET;
            end
            S_SET: begin
                if (pc) m_state = S_IDLE;
                else if (ps) begin m_code = int'(code_in); m_state = S_IDLE; end
            end
            S_ALARM: if (pc) m_state = S_IDLE;
            S_LOCK: begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_state = S_IDLE; m_tries = MT; end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    function automatic int exp_led();
        if (m_state == S_ALARM) return (m_blink >> BB) & 1;
        if (m_state == S_LOCK)  return (m_blink >> (BB - 1)) & 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("state",      32'(state),      m_state);
        check("unlocked",   32'(unlocked),   32'(m_state == S_OPEN));
        check("locked_out", 32'(locked_out), 32'(m_state == S_LOCK));
        check("tries_left", 32'(tries_left), m_tries);
        check("alarm_led",  32'(alarm_led),  exp_led());
        if (locked_out === 1'b1) lo_count++;
        @(negedge clk);
    endtask

    task automatic press(input bit c, input bit s, input logic [CW-1:0] code, input int hold);
        code_in = code; check_btn = !c; set_btn = !s;
        repeat (hold) tick();
        check_btn = 1'b1; set_btn = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int toggles;
        logic prev;
        rst_n = 1'b0; set_btn = 1'b1; check_btn = 1'b1; code_in = '0;
        @(negedge clk);
        tick(); tick();
        rst_n = 1'b1;
        check("rst_state", 32'(state), S_IDLE);
        check("rst_tries", 32'(tries_left), 3);
        check("rst_alarm", 32'(alarm_led), 0);

        // Two-edge press latency.
        check_btn = 1'b0; tick();
        check("lat_k", 32'(state), S_IDLE);
        check_btn = 1'b1; tick();
        check("lat_k1", 32'(state), S_IDLE);
        tick();
        check("lat_k2", 32'(state), S_INPUT);
        repeat (2) tick();
        press(1, 0, 7'h00, 1);
        check("open_default", 32'(state), S_OPEN);
        check("open_unlocked", 32'(unlocked), 1);
        check("open_tries", 32'(tries_left), 3);

        // Change code to 0x55, reopen, then fail once.
        press(0, 1, 7'h00, 1);
        check("set_await", 32'(state), S_SET);
        press(0, 1, 7'h55, 1);
        check("set_done", 32'(state), S_IDLE);
        press(1, 0, 7'h55, 1);
        press(1, 0, 7'h55, 1);
        check("open_new", 32'(state), S_OPEN);
        press(1, 0, 7'h55, 1);
        press(1, 0, 7'h00, 1);
        press(1, 0, 7'h00, 1);
        check("alarm1", 32'(state), S_ALARM);
        check("alarm1_tries", 32'(tries_left), 2);

        prev = alarm_led; toggles = 0;
        repeat (16) begin
            tick();
            if (alarm_led !== prev) toggles++;
            prev = alarm_led;
        end
        check("alarm_toggles", 32'(toggles), 4);

        press(1, 0, 7'h00, 1);
        press(1, 0, 7'h00, 1);
        press(1, 0, 7'h00, 1);
        check("alarm2_tries", 32'(tries_left), 1);
        press(1, 0, 7'h00, 1);
        press(1, 0, 7'h00, 1);
        lo_count = 0;
        press(1, 0, 7'h00, 1);
        check("lockout", 32'(state), S_LOCK);
        check("lockout_tries", 32'(tries_left), 0);

        // Presses during lockout are ignored; lockout blink is twice as fast.
        prev = alarm_led; toggles = 0;
        repeat (8) begin
            check_btn = 1'(($urandom >> 3) & 1); set_btn = 1'(($urandom >> 5) & 1);
            code_in = 7'h55;
            tick();
            if (alarm_led !== prev) toggles++;
            prev = alarm_led;
        end
        check("lock_toggles", 32'(toggles), 4);
        check_btn = 1'b1; set_btn = 1'b1;
        repeat (12) tick();
        check("lock_dwell", 32'(lo_count), LC);
        check("lock_exit", 32'(state), S_IDLE);
        check("lock_exit_tries", 32'(tries_left), 3);

        // Simultaneous chk+set with correct code opens; long hold is one press.
        press(1, 0, 7'h55, 1);
        press(1, 1, 7'h55, 1);
        check("chk_priority", 32'(state), S_OPEN);
        press(1, 0, 7'h55, 50);
        check("hold_single", 32'(state), S_IDLE);

        // Code 0x12, lock out, reset mid-lockout: default code works again.
        press(1, 0, 7'h55, 1);
        press(1, 0, 7'h55, 1);
        press(0, 1, 7'h55, 1);
        press(0, 1, 7'h12, 1);
        repeat (2) begin
            press(1, 0, 7'h00, 1);
            press(1, 0, 7'h00, 1);
            press(1, 0, 7'h00, 1);
        end
        press(1, 0, 7'h00, 1);
        press(1, 0, 7'h00, 1);
        check("lock2", 32'(state), S_LOCK);
        repeat (3) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mid_rst_state", 32'(state), S_IDLE);
        check("mid_rst_locked", 32'(locked_out), 0);
        check("mid_rst_tries", 32'(tries_left), 3);
        tick();
        press(1, 0, 7'h00, 1);
        press(1, 0, 7'h00, 1);
        check("rst_code_open", 32'(state), S_OPEN);

        // Random pin activity.
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) check_btn = ~check_btn;
            if ($urandom_range(0, 4) == 0) set_btn = ~set_btn;
            code_in = ($urandom_range(0, 1) == 1) ? CW'(m_code) : CW'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
